pong_match_sequencer: RTL and testbench
=======================================

Name: pong_match_sequencer

Overview:
Round and match controller for the Pong game, clocked in the 25 MHz pixel domain. Takes the debounced start button and the ball logic's miss pulses, and sequences each round as serve, play, point and game-over. Owns both score registers and drives the enables that gate ball and paddle motion. Counts time in frames, using the Vsync output of the sync pulse generator.

Parameters:
WIN_SCORE, 7, points needed to win; must be < 2**SCORE_W
SCORE_W, 4, score register width
SERVE_FRAMES, 60, frames the ball is held at centre before launch (must be >= 1)
POINT_FRAMES, 90, frames the display is frozen after a point (must be >= 1)

Ports:
clock  in  1  25 MHz pixel clock
reset_n  in  1  asynchronous active-low reset
in_Vsync  in  1  Vsync from the sync pulse generator, active-low pulse
start  in  1  debounced start level
p1_miss  in  1  1-cycle pulse: ball passed P1's paddle, so P2 scores
p2_miss  in  1  1-cycle pulse: ball passed P2's paddle, so P1 scores
ball_reset  out  1  holds the ball at centre
ball_enable  out  1  ball motion allowed
paddle_enable  out  1  paddle motion allowed
serve_dir  out  1  0 = launch toward P1 (left), 1 = toward P2 (right)
p1_score  out  SCORE_W  P1 points
p2_score  out  SCORE_W  P2 points
winner  out  2  00 none, 01 P1, 10 P2
state  out  3  current state encoding

Behaviour:
- frame_tick: 1-cycle pulse on each falling edge of in_Vsync (one per frame). start_rise: 1-cycle pulse on each rising edge of start. Both edge detectors reset to "previous = 1", so a level that is already high at reset does not fire.
- States (encoding): IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4, PAUSED=5 (only with the optional feature).
- Reset (async assert, sync release): state=IDLE, scores=0, winner=00, serve_dir=0, frame counter=0, ball_reset=1, ball_enable=0, paddle_enable=0.
- All outputs are registered and decoded from the next state, so they change in the same cycle as state.
- IDLE: ball_reset=1, both enables 0. On start_rise: clear scores and winner, load counter=SERVE_FRAMES-1, go to SERVE.
- SERVE: ball_reset=1, paddle_enable=1. On frame_tick: if counter=0 go to PLAY, else decrement.
- PLAY: ball_enable=1, paddle_enable=1, ball_reset=0.
  - p1_miss only: p2_score+1, serve_dir=0 (the loser receives the serve).
  - p2_miss only: p1_score+1, serve_dir=1.
  - Both in the same cycle: no score change, serve_dir toggles.
  - Any miss loads counter=POINT_FRAMES-1 and goes to POINT.
  - Latency: miss at cycle N gives updated score and state=POINT at N+1.
- POINT: both enables 0, ball_reset=0 (ball frozen where it exited). On frame_tick with counter=0:
  - p1_score=WIN_SCORE: winner=01, go to GAME_OVER.
  - else p2_score=WIN_SCORE: winner=10, go to GAME_OVER.
  - else load counter=SERVE_FRAMES-1 and go to SERVE.
  - Otherwise decrement the counter on each frame_tick.
- GAME_OVER: ball_reset=1, enables 0, scores and winner held. On start_rise: clear scores and winner, serve_dir=0, go to SERVE with counter=SERVE_FRAMES-1.
- Ignored events: miss pulses outside PLAY; start_rise in SERVE and POINT (and in PLAY unless the optional feature is compiled in).
- Scores only increment in PLAY, and a match always ends at WIN_SCORE, so scores never wrap.
- frame_tick and start_rise in the same cycle: the state-specific rule applies; no state acts on both.
- reset_n asserted in any state returns everything to reset values immediately (asynchronously).

Optional Feature:
Macro PONG_PAUSE_EN.
- Defined: start_rise in PLAY goes to PAUSED (all enables 0, ball_reset=0, scores held, miss pulses ignored). start_rise in PAUSED returns to PLAY. frame_tick has no effect while PAUSED.
- Not defined: the PAUSED state and its logic are absent, and start_rise in PLAY is ignored.

Decomposition:
- Package pong_pkg holds:
  - state encodings (localparams, 3 bits)
  - winner encodings
  - the counter-width function clog2 of max(SERVE_FRAMES, POINT_FRAMES)
- One sub-module, edge_pulse: registered rising/falling edge detector with a reset value parameter. It is instantiated twice, once for Vsync (falling edge) and once for start (rising edge).

Test Plan:
- Reset with start held high, then release reset_n → state=0, scores 0, no transition until start falls and rises again.
- start_rise in IDLE, SERVE_FRAMES=3 → state=1, then state=2 on the cycle after the 3rd frame_tick; ball_enable=1 from that cycle.
- In PLAY, pulse p2_miss → next cycle p1_score=1, serve_dir=1, state=3; after POINT_FRAMES ticks state=1.
- p1_miss and p2_miss in the same cycle → scores unchanged, serve_dir toggled, state=3.
- p1_score=6, WIN_SCORE=7, pulse p2_miss → after POINT frames state=4, winner=01; a miss pulse now leaves scores unchanged; start_rise → scores 0, state=1.
- With PONG_PAUSE_EN: start_rise in PLAY → state=5, enables 0; p1_miss ignored; second start_rise → state=2. Without the macro, the same start_rise leaves state=2.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared encodings for the Pong round/match sequencer: FSM states, winner codes
// and the frame-counter width helper. PAUSED exists only when PONG_PAUSE_EN is defined.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
`ifdef PONG_PAUSE_EN
    , ST_PAUSED  = 3'd5
`endif
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Counter holds values 0..max-1, so clog2(max) bits, never fewer than one.
  function automatic int cnt_width(input int serve_frames, input int point_frames);
    int m;
    int w;
    m = (serve_frames > point_frames) ? serve_frames : point_frames;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered edge detector: one-cycle strobe on a rising (RISING=1) or falling
// (RISING=0) edge of d. The history register resets to RESET_VAL.
module edge_pulse #(
  parameter logic RESET_VAL = 1'b1,
  parameter logic RISING    = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev_q <= RESET_VAL;
    else          prev_q <= d;
  end

  assign pulse = RISING ? (d & ~prev_q) : (~d & prev_q);

endmodule

// File: rtl/pong_match_sequencer.sv
// Pong round/match sequencer: serve, play, point and game-over timed in frames.
// Optional pause on start in PLAY is compiled in with macro PONG_PAUSE_EN.
module pong_match_sequencer
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_Vsync,
  input  logic               start,
  input  logic               p1_miss,
  input  logic               p2_miss,
  output logic               ball_reset,
  output logic               ball_enable,
  output logic               paddle_enable,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam int                 CW         = cnt_width(SERVE_FRAMES, POINT_FRAMES);
  localparam logic [CW-1:0]      SERVE_LOAD = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0]      POINT_LOAD = CW'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  // frame_tick and start_rise are single-cycle strobes with no back-pressure:
  // an event is acted on only if the current state cares about it that cycle.
  logic frame_tick;
  logic start_rise;

  edge_pulse #(.RESET_VAL(1'b1), .RISING(1'b0)) u_vsync_edge (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (in_Vsync),
    .pulse  (frame_tick)
  );

  edge_pulse #(.RESET_VAL(1'b1), .RISING(1'b1)) u_start_edge (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (start),
    .pulse  (start_rise)
  );

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         win_q, win_d;
  logic               dir_q, dir_d;
  logic               br_d, be_d, pe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          p1_d    = '0;
          p2_d    = '0;
          win_d   = WIN_NONE;
          cnt_d   = SERVE_LOAD;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == '0) state_d = ST_PLAY;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_PLAY: begin
        if (p1_miss || p2_miss) begin
          cnt_d   = POINT_LOAD;
          state_d = ST_POINT;
          // Simultaneous misses score nobody; only the serve side flips.
          if (p1_miss && p2_miss) begin
            dir_d = ~dir_q;
          end else if (p1_miss) begin
            p2_d  = p2_q + 1'b1;
            dir_d = 1'b0;
          end else begin
            p1_d  = p1_q + 1'b1;
            dir_d = 1'b1;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (start_rise) begin
          state_d = ST_PAUSED;
        end
`endif
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (p1_q == WIN_VAL) begin
            win_d   = WIN_P1;
            state_d = ST_GAME_OVER;
          end else if (p2_q == WIN_VAL) begin
            win_d   = WIN_P2;
            state_d = ST_GAME_OVER;
          end else begin
            cnt_d   = SERVE_LOAD;
            state_d = ST_SERVE;
          end
        end
      end
      ST_GAME_OVER: begin
        if (start_rise) begin
          p1_d    = '0;
          p2_d    = '0;
          win_d   = WIN_NONE;
          dir_d   = 1'b0;
          cnt_d   = SERVE_LOAD;
          state_d = ST_SERVE;
        end
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSED: begin
        if (start_rise) state_d = ST_PLAY;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Motion controls are decoded from the next state so they register with it.
    br_d = 1'b0;
    be_d = 1'b0;
    pe_d = 1'b0;
    case (state_d)
      ST_IDLE:      br_d = 1'b1;
      ST_SERVE:     begin br_d = 1'b1; pe_d = 1'b1; end
      ST_PLAY:      begin be_d = 1'b1; pe_d = 1'b1; end
      ST_GAME_OVER: br_d = 1'b1;
      default:      br_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      p1_q          <= '0;
      p2_q          <= '0;
      win_q         <= WIN_NONE;
      dir_q         <= 1'b0;
      ball_reset    <= 1'b1;
      ball_enable   <= 1'b0;
      paddle_enable <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      win_q         <= win_d;
      dir_q         <= dir_d;
      ball_reset    <= br_d;
      ball_enable   <= be_d;
      paddle_enable <= pe_d;
    end
  end

  assign state     = state_q;
  assign p1_score  = p1_q;
  assign p2_score  = p2_q;
  assign winner    = win_q;
  assign serve_dir = dir_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Scoreboard bench for pong_match_sequencer with short serve/point timers so a
// full match to WIN_SCORE fits in a few thousand cycles.
module tb_pong_match_sequencer;

  localparam int WIN = 7;
  localparam int SW  = 4;
  localparam int SF  = 3;
  localparam int PF  = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_GO    = 3'd4;
  localparam logic [2:0] S_PAUSE = 3'd5;

  logic          clock = 1'b0;
  logic          reset_n, in_Vsync, start, p1_miss, p2_miss;
  logic          ball_reset, ball_enable, paddle_enable, serve_dir;
  logic [SW-1:0] p1_score, p2_score;
  logic [1:0]    winner;
  logic [2:0]    state;

  always #5 clock = ~clock;

  pong_match_sequencer #(
    .WIN_SCORE(WIN), .SCORE_W(SW), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_Vsync     (in_Vsync),
    .start        (start),
    .p1_miss      (p1_miss),
    .p2_miss      (p2_miss),
    .ball_reset   (ball_reset),
    .ball_enable  (ball_enable),
    .paddle_enable(paddle_enable),
    .serve_dir    (serve_dir),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .winner       (winner),
    .state        (state)
  );

  int errors = 0;
  int checks = 0;

  // Expected snapshot: {state, p1, p2, winner, serve_dir, ball_reset, ball_enable, paddle_enable}
  logic [16:0] exp_q[$];
  string       name_q[$];

  logic [2:0]    e_st;
  logic [SW-1:0] e_p1, e_p2;
  logic [1:0]    e_win;
  logic          e_dir;

  function automatic logic [16:0] mk(input logic [2:0] st, input logic [SW-1:0] a,
                                     input logic [SW-1:0] b, input logic [1:0] w,
                                     input logic dir);
    logic br, be, pe;
    case (st)
      S_IDLE:  begin br = 1; be = 0; pe = 0; end
      S_SERVE: begin br = 1; be = 0; pe = 1; end
      S_PLAY:  begin br = 0; be = 1; pe = 1; end
      S_GO:    begin br = 1; be = 0; pe = 0; end
      default: begin br = 0; be = 0; pe = 0; end
    endcase
    return {st, a, b, w, dir, br, be, pe};
  endfunction

  task automatic expect_cur(input string nm);
    exp_q.push_back(mk(e_st, e_p1, e_p2, e_win, e_dir));
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are stable mid-cycle, so every pending expectation is compared there.
  always @(negedge clock) begin
    logic [16:0] got, exp;
    string nm;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {state, p1_score, p2_score, winner, serve_dir, ball_reset, ball_enable, paddle_enable};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got st=%0d p1=%0d p2=%0d win=%b dir=%b br/be/pe=%b, expected st=%0d p1=%0d p2=%0d win=%b dir=%b br/be/pe=%b",
                 nm, got[16:14], got[13:10], got[9:6], got[5:4], got[3], got[2:0],
                 exp[16:14], exp[13:10], exp[9:6], exp[5:4], exp[3], exp[2:0]);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic frame();
    in_Vsync = 1'b0;
    step();
    in_Vsync = 1'b1;
    step();
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic play_miss(input logic m1, input logic m2);
    p1_miss = m1;
    p2_miss = m2;
    step();
    p1_miss = 1'b0;
    p2_miss = 1'b0;
    if (m1 && !m2) begin
      e_p2  = e_p2 + 1'b1;
      e_dir = 1'b0;
    end else if (m2 && !m1) begin
      e_p1  = e_p1 + 1'b1;
      e_dir = 1'b1;
    end else begin
      e_dir = ~e_dir;
    end
    e_st = S_POINT;
    expect_cur("miss_to_point");
  endtask

  task automatic point_to_next();
    frame();
    expect_cur("point_hold");
    frame();
    if (e_p1 == SW'(WIN)) begin
      e_win = 2'b01;
      e_st  = S_GO;
    end else if (e_p2 == SW'(WIN)) begin
      e_win = 2'b10;
      e_st  = S_GO;
    end else begin
      e_st = S_SERVE;
    end
    expect_cur("point_done");
  endtask

  task automatic serve_to_play();
    frame();
    frame();
    expect_cur("serve_hold");
    in_Vsync = 1'b0;
    step();
    e_st = S_PLAY;
    expect_cur("serve_launch");
    in_Vsync = 1'b1;
    step();
  endtask

  initial begin
    reset_n  = 1'b0;
    in_Vsync = 1'b1;
    start    = 1'b1;
    p1_miss  = 1'b0;
    p2_miss  = 1'b0;
    e_st = S_IDLE; e_p1 = '0; e_p2 = '0; e_win = 2'b00; e_dir = 1'b0;

    repeat (3) step();
    expect_cur("reset_state");
    reset_n = 1'b1;
    repeat (3) step();
    expect_cur("idle_start_held_high");
    start = 1'b0;
    step();
    expect_cur("idle_start_low");
    start = 1'b1;
    step();
    e_st = S_SERVE;
    expect_cur("start_to_serve");
    start = 1'b0;
    repeat (3) step();
    expect_cur("serve_waits_for_frames");

    serve_to_play();
    play_miss(1'b0, 1'b1);
    point_to_next();

    p1_miss = 1'b1;
    step();
    p1_miss = 1'b0;
    step();
    expect_cur("serve_miss_ignored");
    press_start();
    expect_cur("serve_start_ignored");

    serve_to_play();
    play_miss(1'b1, 1'b1);
    point_to_next();
    serve_to_play();
    play_miss(1'b1, 1'b0);
    point_to_next();
    serve_to_play();

    start = 1'b1;
    step();
    start = 1'b0;
`ifdef PONG_PAUSE_EN
    e_st = S_PAUSE;
    expect_cur("pause_enter");
    step();
    p1_miss = 1'b1;
    step();
    p1_miss = 1'b0;
    expect_cur("pause_miss_ignored");
    frame();
    expect_cur("pause_frame_ignored");
    start = 1'b1;
    step();
    start = 1'b0;
    e_st = S_PLAY;
    expect_cur("pause_exit");
    step();
`else
    expect_cur("play_start_ignored");
    step();
`endif

    for (int i = 0; i < 5; i++) begin
      play_miss(1'b0, 1'b1);
      point_to_next();
      serve_to_play();
    end
    play_miss(1'b0, 1'b1);
    point_to_next();

    p2_miss = 1'b1;
    step();
    p2_miss = 1'b0;
    step();
    expect_cur("gameover_miss_ignored");
    frame();
    expect_cur("gameover_frame_ignored");
    press_start();
    e_st = S_SERVE; e_p1 = '0; e_p2 = '0; e_win = 2'b00; e_dir = 1'b0;
    expect_cur("restart_from_gameover");

    serve_to_play();
    for (int i = 0; i < WIN; i++) begin
      play_miss(1'b1, 1'b0);
      point_to_next();
      if (e_st == S_SERVE) serve_to_play();
    end

    press_start();
    e_st = S_SERVE; e_p1 = '0; e_p2 = '0; e_win = 2'b00; e_dir = 1'b0;
    expect_cur("restart_again");
    step();
    #2 reset_n = 1'b0;
    #1;
    e_st = S_IDLE;
    expect_cur("async_reset");
    step();
    reset_n = 1'b1;
    step();
    expect_cur("idle_after_reset");

    repeat (2) step();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
